// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared command codes and state encoding for the program loader
package program_loader_pkg;

  localparam logic [7:0] CMD_RAM  = 8'hA5;
  localparam logic [7:0] CMD_MC   = 8'h5A;
  localparam logic [7:0] CMD_RUN  = 8'h0F;
  localparam logic [7:0] CMD_STOP = 8'hC3;

  typedef enum logic [3:0] {
    IDLE,
    RAM_LEN,
    RAM_BYTE,
    RAM_MAR,
    RAM_WR,
    MC_LEN0,
    MC_LEN1,
    MC_BYTE,
    MC_WR,
    RUN,
    ERR
  } loader_state_t;

endpackage

// File: rtl/loader_word_assembler.sv
// rtl/loader_word_assembler.sv - LSB-first byte-lane shift register building one microcode word
module loader_word_assembler #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift,
  input  logic [7:0]       data,
  output logic [WIDTH-1:0] word,
  output logic             complete
);

  localparam int BYTES = WIDTH / 8;
  localparam int CW = $clog2(BYTES) + 1;
  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

  logic [CW-1:0] count;

  // The byte being shifted in now closes the word when the count sits on the last lane.
  assign complete = shift && (count == LAST);

  // Byte counter restarts on every completed word so words need no explicit re-arm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (shift) begin
      count <= complete ? '0 : count + 1'b1;
    end
  end

  generate
    if (BYTES == 1) begin : g_single
      assign word = data;
    end else begin : g_multi
      localparam int PW = WIDTH - 8;
      logic [PW-1:0] lanes;

      // The incoming byte is the top lane of the finished word; earlier bytes sit below it.
      assign word = {data, lanes};

      if (PW == 8) begin : g_one_lane
        // Single held lane: just capture the byte.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            lanes <= '0;
          end else if (clear) begin
            lanes <= '0;
          end else if (shift) begin
            lanes <= data;
          end
        end
      end else begin : g_shift_lanes
        // Shift right by a byte so the first byte received ends up in the lowest lane.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            lanes <= '0;
          end else if (clear) begin
            lanes <= '0;
          end else if (shift) begin
            lanes <= {data, lanes[PW-1:8]};
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream loader for RAM image and microcode, with run control
module program_loader
  import program_loader_pkg::*;
#(
  parameter int RAM_SIZE       = 256,
  parameter int EEPROM_SIZE    = 1024,
  parameter int MICROCODE_SIZE = 24
) (
  input  logic                      clk,
  input  logic                      RESET,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic                      rx_ready,
  output logic [7:0]                GLOBAL_BUS,
  output logic                      mar_in,
  output logic                      ram_in,
  output logic                      eeprom_in,
  output logic [MICROCODE_SIZE-1:0] microcode,
  output logic                      RESET_counter,
  output logic                      RESETn,
  output logic                      busy,
  output logic                      error
);

  localparam logic [8:0] FULL_IMAGE = 9'(RAM_SIZE);

  loader_state_t             state;
  logic [7:0]                addr;
  logic [7:0]                data_q;
  logic [7:0]                wc_lo;
  logic [8:0]                ram_left;
  logic [15:0]               words_left;
  logic [15:0]               wc;
  logic                      accept;
  logic                      asm_shift;
  logic                      asm_clear;
  logic                      asm_complete;
  logic [MICROCODE_SIZE-1:0] asm_word;

  assign accept    = rx_valid && rx_ready;
  assign wc        = {rx_data, wc_lo};
  assign asm_shift = accept && (state == MC_BYTE);
  assign asm_clear = accept && (state == MC_LEN1);

  assign rx_ready   = state inside {IDLE, RAM_LEN, RAM_BYTE, MC_LEN0, MC_LEN1, MC_BYTE, RUN};
  assign mar_in     = (state == RAM_MAR);
  assign ram_in     = (state == RAM_WR);
  assign eeprom_in  = (state == MC_WR);
  assign RESETn     = (state == RUN);
  assign error      = (state == ERR);
  assign busy       = !(state inside {IDLE, RUN, ERR});
  assign GLOBAL_BUS = (state == RAM_MAR) ? addr : (state == RAM_WR) ? data_q : 8'h00;

  loader_word_assembler #(
    .WIDTH(MICROCODE_SIZE)
  ) u_asm (
    .clk     (clk),
    .rst     (RESET),
    .clear   (asm_clear),
    .shift   (asm_shift),
    .data    (rx_data),
    .word    (asm_word),
    .complete(asm_complete)
  );

  // Loader sequencer: command decode, RAM image write cycles, microcode word writes, run hold.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      addr          <= '0;
      data_q        <= '0;
      wc_lo         <= '0;
      ram_left      <= '0;
      words_left    <= '0;
      microcode     <= '0;
      RESET_counter <= 1'b0;
    end else begin
      RESET_counter <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (rx_data)
              CMD_RAM: state <= RAM_LEN;
              CMD_MC: begin
                state         <= MC_LEN0;
                RESET_counter <= 1'b1;
              end
              CMD_RUN: begin
                state         <= RUN;
                RESET_counter <= 1'b1;
              end
              default: state <= ERR;
            endcase
          end
        end
        RAM_LEN: begin
          if (accept) begin
            ram_left <= (rx_data == 8'h00) ? FULL_IMAGE : {1'b0, rx_data};
            addr     <= '0;
            state    <= RAM_BYTE;
          end
        end
        RAM_BYTE: begin
          if (accept) begin
            data_q <= rx_data;
            state  <= RAM_MAR;
          end
        end
        RAM_MAR: state <= RAM_WR;
        RAM_WR: begin
          // Address advances after each write, so it only wraps after the 256th byte.
          addr     <= addr + 8'd1;
          ram_left <= ram_left - 9'd1;
          state    <= (ram_left == 9'd1) ? IDLE : RAM_BYTE;
        end
        MC_LEN0: begin
          if (accept) begin
            wc_lo <= rx_data;
            state <= MC_LEN1;
          end
        end
        MC_LEN1: begin
          if (accept) begin
            if (wc == 16'd0) begin
              state <= IDLE;
            end else if (int'(wc) > EEPROM_SIZE) begin
              state <= ERR;
            end else begin
              words_left <= wc;
              state      <= MC_BYTE;
            end
          end
        end
        MC_BYTE: begin
          if (accept && asm_complete) begin
            microcode <= asm_word;
            state     <= MC_WR;
          end
        end
        MC_WR: begin
          words_left <= words_left - 16'd1;
          state      <= (words_left == 16'd1) ? IDLE : MC_BYTE;
        end
        RUN: begin
          if (accept && (rx_data == CMD_STOP)) begin
            state <= IDLE;
          end
        end
        ERR:     state <= ERR;
        default: state <= ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader
module tb_program_loader;

  logic        clk = 1'b0;
  logic        RESET;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  GLOBAL_BUS;
  logic        mar_in;
  logic        ram_in;
  logic        eeprom_in;
  logic [23:0] microcode;
  logic        RESET_counter;
  logic        RESETn;
  logic        busy;
  logic        error;

  program_loader dut (
    .clk          (clk),
    .RESET        (RESET),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .GLOBAL_BUS   (GLOBAL_BUS),
    .mar_in       (mar_in),
    .ram_in       (ram_in),
    .eeprom_in    (eeprom_in),
    .microcode    (microcode),
    .RESET_counter(RESET_counter),
    .RESETn       (RESETn),
    .busy         (busy),
    .error        (error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rc_cnt = 0;
  int excl_viol = 0;
  int bus_viol = 0;
  int last_ram_cyc = 0;
  logic [7:0]  mar_q[$];
  logic [7:0]  ram_q[$];
  logic [23:0] ee_q[$];
  logic [23:0] last_word = 24'h0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log of every strobe observed on the computer side.
  always @(negedge clk) begin
    if (!RESET) begin
      if (mar_in) mar_q.push_back(GLOBAL_BUS);
      if (ram_in) begin
        ram_q.push_back(GLOBAL_BUS);
        last_ram_cyc = cyc;
      end
      if (eeprom_in) ee_q.push_back(microcode);
      if (RESET_counter) rc_cnt++;
      if (int'(mar_in) + int'(ram_in) + int'(eeprom_in) + int'(RESET_counter) > 1) excl_viol++;
      if (!mar_in && !ram_in && GLOBAL_BUS != 8'h00) bus_viol++;
    end
  end

  task clear_log();
    mar_q.delete();
    ram_q.delete();
    ee_q.delete();
  endtask

  task send(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (!rx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout byte=%02h: rx_ready stayed 0, required 1", b);
      rx_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
    end
  endtask

  task wait_idle(output int c);
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: busy stayed 1, required 0");
    end
    c = cyc;
  endtask

  task do_reset();
    @(negedge clk);
    RESET = 1'b1;
    repeat (2) @(negedge clk);
    RESET = 1'b0;
  endtask

  task test_reset();
    logic [39:0] obs;
    logic [39:0] exp_v;
    exp_v = 40'd1 << 39;
    RESET = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    #12;
    obs = {rx_ready, GLOBAL_BUS, mar_in, ram_in, eeprom_in, microcode, RESET_counter, RESETn, busy, error};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL reset_outputs: got %h, required %h", obs, exp_v);
    end
    repeat (2) @(negedge clk);
    RESET = 1'b0;
    @(negedge clk);
    obs = {rx_ready, GLOBAL_BUS, mar_in, ram_in, eeprom_in, microcode, RESET_counter, RESETn, busy, error};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL post_reset_idle: got %h, required %h", obs, exp_v);
    end
  endtask

  task test_ram_short();
    int c0, c1;
    logic [7:0] exp_d[3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    clear_log();
    send(8'hA5, 0);
    send(8'h03, 0);
    send(8'h11, 0);
    c0 = cyc;
    send(8'h22, 0);
    send(8'h33, 0);
    wait_idle(c1);
    tests++;
    if (c1 - c0 !== 8) begin
      fails++;
      $display("FAIL ram_short_latency: idle %0d edges after 0x11, required 8", c1 - c0);
    end
    tests++;
    if (mar_q.size() !== 3 || ram_q.size() !== 3) begin
      fails++;
      $display("FAIL ram_short_count: mar=%0d ram=%0d, required 3/3", mar_q.size(), ram_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (mar_q[i] !== 8'(i) || ram_q[i] !== exp_d[i]) begin
          fails++;
          $display("FAIL ram_short_pair%0d: addr %02h data %02h, required %02h %02h", i, mar_q[i], ram_q[i], 8'(i), exp_d[i]);
        end
      end
    end
  endtask

  task test_ram_random();
    int n, c;
    logic [7:0] img[$];
    for (int r = 0; r < 3; r++) begin
      clear_log();
      img.delete();
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) img.push_back(8'($urandom));
      send(8'hA5, $urandom_range(0, 3));
      send(8'(n), $urandom_range(0, 3));
      for (int i = 0; i < n; i++) send(img[i], $urandom_range(0, 3));
      wait_idle(c);
      tests++;
      if (ram_q.size() !== n || mar_q.size() !== n) begin
        fails++;
        $display("FAIL ram_random_count: mar=%0d ram=%0d, required %0d", mar_q.size(), ram_q.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          tests++;
          if (mar_q[i] !== 8'(i) || ram_q[i] !== img[i]) begin
            fails++;
            $display("FAIL ram_random_pair%0d: addr %02h data %02h, required %02h %02h", i, mar_q[i], ram_q[i], 8'(i), img[i]);
          end
        end
      end
    end
  endtask

  task test_ram_full();
    int c, bad;
    logic [7:0] img[256];
    clear_log();
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    send(8'hA5, 0);
    send(8'h00, 0);
    for (int i = 0; i < 256; i++) send(img[i], 0);
    wait_idle(c);
    tests++;
    if (ram_q.size() !== 256 || mar_q.size() !== 256) begin
      fails++;
      $display("FAIL ram_full_count: mar=%0d ram=%0d, required 256", mar_q.size(), ram_q.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 256; i++) if (mar_q[i] !== 8'(i) || ram_q[i] !== img[i]) bad++;
      tests++;
      if (bad !== 0) begin
        fails++;
        $display("FAIL ram_full_pairs: %0d wrong address/data pairs, required 0", bad);
      end
    end
    tests++;
    if (c !== last_ram_cyc + 1) begin
      fails++;
      $display("FAIL ram_full_busy_fall: busy fell at %0d, required %0d", c, last_ram_cyc + 1);
    end
  endtask

  task test_microcode();
    int rc0, c, w;
    logic [7:0] bytes_q[$];
    logic [23:0] exp_w[$];
    clear_log();
    rc0 = rc_cnt;
    send(8'h5A, 0); send(8'h02, 0); send(8'h00, 0);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0);
    wait_idle(c);
    tests++;
    if (rc_cnt - rc0 !== 1) begin
      fails++;
      $display("FAIL mc_reset_counter: %0d pulses, required 1", rc_cnt - rc0);
    end
    tests++;
    if (ee_q.size() !== 2 || ee_q[0] !== 24'h030201 || ee_q[1] !== 24'hCCBBAA) begin
      fails++;
      $display("FAIL mc_fixed_words: n=%0d w0=%h w1=%h, required 2 030201 ccbbaa", ee_q.size(), ee_q[0], ee_q[1]);
    end
    last_word = 24'hCCBBAA;
    tests++;
    if (microcode !== last_word) begin
      fails++;
      $display("FAIL mc_hold: microcode %h, required %h", microcode, last_word);
    end
    for (int r = 0; r < 2; r++) begin
      clear_log();
      bytes_q.delete();
      exp_w.delete();
      w = $urandom_range(1, 4);
      for (int i = 0; i < 3 * w; i++) bytes_q.push_back(8'($urandom));
      for (int k = 0; k < w; k++)
        exp_w.push_back(24'(int'(bytes_q[3*k]) + 256 * int'(bytes_q[3*k+1]) + 65536 * int'(bytes_q[3*k+2])));
      send(8'h5A, $urandom_range(0, 2));
      send(8'(w), $urandom_range(0, 2));
      send(8'h00, $urandom_range(0, 2));
      for (int i = 0; i < 3 * w; i++) send(bytes_q[i], $urandom_range(0, 2));
      wait_idle(c);
      tests++;
      if (ee_q.size() !== w) begin
        fails++;
        $display("FAIL mc_random_count: %0d words, required %0d", ee_q.size(), w);
      end else begin
        for (int k = 0; k < w; k++) begin
          tests++;
          if (ee_q[k] !== exp_w[k]) begin
            fails++;
            $display("FAIL mc_random_word%0d: %h, required %h", k, ee_q[k], exp_w[k]);
          end
        end
      end
      last_word = exp_w[w-1];
    end
  endtask

  task test_mc_zero();
    clear_log();
    send(8'h5A, 0); send(8'h00, 0); send(8'h00, 0);
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || error !== 1'b0 || ee_q.size() !== 0 || microcode !== last_word) begin
      fails++;
      $display("FAIL mc_zero: busy=%b error=%b writes=%0d microcode=%h, required 0 0 0 %h", busy, error, ee_q.size(), microcode, last_word);
    end
  endtask

  task test_mc_boundary();
    int c, bad;
    logic [7:0] bytes_q[$];
    clear_log();
    bytes_q.delete();
    for (int i = 0; i < 3 * 1024; i++) bytes_q.push_back(8'($urandom));
    send(8'h5A, 0); send(8'h00, 0); send(8'h04, 0);
    for (int i = 0; i < 3 * 1024; i++) send(bytes_q[i], 0);
    wait_idle(c);
    tests++;
    if (error !== 1'b0 || ee_q.size() !== 1024) begin
      fails++;
      $display("FAIL mc_max_words: error=%b writes=%0d, required 0 1024", error, ee_q.size());
    end else begin
      bad = 0;
      for (int k = 0; k < 1024; k++)
        if (ee_q[k] !== 24'(int'(bytes_q[3*k]) + 256 * int'(bytes_q[3*k+1]) + 65536 * int'(bytes_q[3*k+2]))) bad++;
      tests++;
      if (bad !== 0) begin
        fails++;
        $display("FAIL mc_max_content: %0d wrong words, required 0", bad);
      end
    end
  endtask

  task test_run();
    int rc0;
    rc0 = rc_cnt;
    send(8'h0F, 0);
    tests++;
    if (RESETn !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL run_enter: RESETn=%b busy=%b, required 1 0", RESETn, busy);
    end
    send(8'h77, 1);
    @(negedge clk);
    tests++;
    if (RESETn !== 1'b1 || error !== 1'b0) begin
      fails++;
      $display("FAIL run_ignore: RESETn=%b error=%b, required 1 0", RESETn, error);
    end
    send(8'hC3, 0);
    tests++;
    if (RESETn !== 1'b0 || rx_ready !== 1'b1) begin
      fails++;
      $display("FAIL run_stop: RESETn=%b rx_ready=%b, required 0 1", RESETn, rx_ready);
    end
    @(negedge clk);
    tests++;
    if (rc_cnt - rc0 !== 1) begin
      fails++;
      $display("FAIL run_reset_counter: %0d pulses, required 1", rc_cnt - rc0);
    end
  endtask

  task test_reset_mid();
    int c;
    logic [7:0] b[5];
    for (int i = 0; i < 5; i++) b[i] = 8'($urandom);
    clear_log();
    send(8'hA5, 0); send(8'h05, 0);
    send(b[0], 0); send(b[1], 0); send(b[2], 0);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (ram_in !== 1'b1 || GLOBAL_BUS !== b[2]) begin
      fails++;
      $display("FAIL mid_wr_setup: ram_in=%b bus=%02h, required 1 %02h", ram_in, GLOBAL_BUS, b[2]);
    end
    #2;
    RESET = 1'b1;
    #1;
    tests++;
    if ({rx_ready, mar_in, ram_in, busy, GLOBAL_BUS} !== 12'b1000_0000_0000) begin
      fails++;
      $display("FAIL mid_reset_idle: rdy=%b mar=%b ram=%b busy=%b bus=%02h, required 1 0 0 0 00", rx_ready, mar_in, ram_in, busy, GLOBAL_BUS);
    end
    repeat (2) @(negedge clk);
    RESET = 1'b0;
    repeat (10) @(negedge clk);
    tests++;
    if (mar_q.size() !== 3 || ram_q.size() !== 3) begin
      fails++;
      $display("FAIL mid_no_strobes: mar=%0d ram=%0d, required 3 3", mar_q.size(), ram_q.size());
    end
    clear_log();
    send(8'hA5, 0); send(8'h02, 0); send(b[3], 0); send(b[4], 0);
    wait_idle(c);
    tests++;
    if (mar_q.size() !== 2 || ram_q.size() !== 2 || mar_q[0] !== 8'h00 || mar_q[1] !== 8'h01 ||
        ram_q[0] !== b[3] || ram_q[1] !== b[4]) begin
      fails++;
      $display("FAIL mid_reload: n=%0d/%0d data %02h %02h, required 2/2 %02h %02h", mar_q.size(), ram_q.size(), ram_q[0], ram_q[1], b[3], b[4]);
    end
  endtask

  task test_error();
    send(8'h5A, 0); send(8'h01, 0); send(8'h04, 0);
    tests++;
    if ({error, rx_ready, RESETn, busy} !== 4'b1000) begin
      fails++;
      $display("FAIL err_len: error=%b rdy=%b RESETn=%b busy=%b, required 1 0 0 0", error, rx_ready, RESETn, busy);
    end
    clear_log();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx_data = (i == 0) ? 8'hC3 : 8'($urandom);
      rx_valid = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    tests++;
    if (error !== 1'b1 || rx_ready !== 1'b0 || ee_q.size() !== 0 || mar_q.size() !== 0) begin
      fails++;
      $display("FAIL err_sticky: error=%b rdy=%b strobes=%0d, required 1 0 0", error, rx_ready, ee_q.size() + mar_q.size());
    end
    do_reset();
    @(negedge clk);
    tests++;
    if (error !== 1'b0 || rx_ready !== 1'b1) begin
      fails++;
      $display("FAIL err_clear: error=%b rdy=%b, required 0 1", error, rx_ready);
    end
    send(8'h33, 0);
    tests++;
    if (error !== 1'b1 || rx_ready !== 1'b0) begin
      fails++;
      $display("FAIL err_bad_cmd: error=%b rdy=%b, required 1 0", error, rx_ready);
    end
    do_reset();
  endtask

  task test_invariants();
    tests++;
    if (excl_viol !== 0) begin
      fails++;
      $display("FAIL strobe_exclusive: %0d cycles with overlapping strobes, required 0", excl_viol);
    end
    tests++;
    if (bus_viol !== 0) begin
      fails++;
      $display("FAIL bus_quiet: %0d cycles with nonzero bus outside writes, required 0", bus_viol);
    end
  endtask

  initial begin
    test_reset();
    test_ram_short();
    test_ram_random();
    test_ram_full();
    test_microcode();
    test_mc_zero();
    test_mc_boundary();
    test_run();
    test_reset_mid();
    test_error();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
